// File: rtl/fp_add_pkg.sv
// Shared types, widths and helpers for the single-precision add/sub sequencer.
package fp_add_pkg;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int FRAC_W = 27;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;
    localparam logic [31:0]      QNAN    = 32'h7FC00000;

    localparam int G_IDX = 2;
    localparam int R_IDX = 1;
    localparam int S_IDX = 0;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ALIGN = 3'd1;
    localparam logic [2:0] ST_ADD   = 3'd2;
    localparam logic [2:0] ST_NORM  = 3'd3;
    localparam logic [2:0] ST_ROUND = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_ALIGN = ST_ALIGN,
        S_ADD   = ST_ADD,
        S_NORM  = ST_NORM,
        S_ROUND = ST_ROUND,
        S_DONE  = ST_DONE
    } state_t;

    // Subnormals (exp field 0) collapse to a zero fraction.
    function automatic logic [FRAC_W-1:0] unpackFrac(input logic [30:0] mag);
        if (mag[30:23] == 8'd0) begin
            return 27'd0;
        end else begin
            return {1'b1, mag[22:0], 3'b000};
        end
    endfunction

    function automatic logic roundUpRne(input logic lsb, input logic g,
                                        input logic r, input logic s);
        return g & (r | s | lsb);
    endfunction

endpackage

// File: rtl/fp_lzc27.sv
// Leading-zero count of a 27-bit working fraction; all-zero input returns 27.
module fp_lzc27
    import fp_add_pkg::*;
(
    input  logic [FRAC_W-1:0] frac,
    output logic [4:0]        count
);

    // Scan upward so the highest set bit wins.
    always_comb begin
        count = 5'd27;
        for (int i = 0; i < FRAC_W; i++) begin
            count = frac[i] ? 5'(26 - i) : count;
        end
    end

endmodule

// File: rtl/fp_add_sequencer.sv
// Multi-cycle IEEE-754 single-precision add/sub sequencer with valid/ready on both sides.
// Define ALIGN_FAST_EN for a single-cycle barrel-shift alignment step (fixed latency 4).
module fp_add_sequencer
    import fp_add_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_overflow,
    output logic        out_zero,
    output logic        busy
);

    state_t state_r, next_s;

    logic                    signRes_r, effSub_r, special_r, sumZero_r;
    logic [31:0]             specialRes_r;
    logic signed [EXP_W+1:0] exp_r;
    logic [FRAC_W-1:0]       fracA_r, fracB_r;
    logic [FRAC_W:0]         sum_r;
    logic [4:0]              alignCnt_r;

    logic        inReady_r, outValid_r, busy_r, overflow_r, zero_r;
    logic [31:0] result_r;

    logic              accept_s, swap_s, signB_s, bigSign_s, special_s;
    logic [30:0]       bigMag_s, smallMag_s;
    logic [EXP_W-1:0]  diff_s;
    logic [4:0]        k_s;
    logic [FRAC_W-1:0] fracSmall_s;
    logic [31:0]       specialCalc_s;
    logic              nanA_s, nanB_s, infA_s, infB_s;
    logic [4:0]        lzc_s;

    logic [24:0]             mantRnd_s;
    logic signed [EXP_W+1:0] expRnd_s;
    logic [MAN_W-1:0]        mantOut_s;

    assign accept_s = (state_r == S_IDLE) && in_valid;

    fp_lzc27 uLzc (
        .frac  (sum_r[FRAC_W-1:0]),
        .count (lzc_s)
    );

    // Operand unpack, magnitude ordering and special-value detection at capture.
    always_comb begin
        signB_s     = in_b[31] ^ in_sub;
        swap_s      = (in_b[30:0] > in_a[30:0]);
        bigMag_s    = swap_s ? in_b[30:0] : in_a[30:0];
        smallMag_s  = swap_s ? in_a[30:0] : in_b[30:0];
        bigSign_s   = swap_s ? signB_s : in_a[31];
        diff_s      = bigMag_s[30:23] - smallMag_s[30:23];
        k_s         = (diff_s >= 8'd27) ? 5'd27 : diff_s[4:0];
        fracSmall_s = unpackFrac(smallMag_s);
        if (diff_s >= 8'd27) begin
            fracSmall_s = {26'd0, |fracSmall_s};
        end else begin
            fracSmall_s = fracSmall_s;
        end

        nanA_s    = (in_a[30:23] == EXP_MAX) && (in_a[22:0] != 23'd0);
        nanB_s    = (in_b[30:23] == EXP_MAX) && (in_b[22:0] != 23'd0);
        infA_s    = (in_a[30:23] == EXP_MAX) && (in_a[22:0] == 23'd0);
        infB_s    = (in_b[30:23] == EXP_MAX) && (in_b[22:0] == 23'd0);
        special_s = (in_a[30:23] == EXP_MAX) || (in_b[30:23] == EXP_MAX);
        if (nanA_s || nanB_s || (infA_s && infB_s && (in_a[31] != signB_s))) begin
            specialCalc_s = QNAN;
        end else if (infA_s) begin
            specialCalc_s = {in_a[31], EXP_MAX, 23'd0};
        end else begin
            specialCalc_s = {signB_s, EXP_MAX, 23'd0};
        end
    end

    // Round-to-nearest-even on the normalised fraction held in fracA_r.
    always_comb begin
        mantRnd_s = {1'b0, fracA_r[FRAC_W-1:3]} +
                    {24'd0, roundUpRne(fracA_r[3], fracA_r[G_IDX], fracA_r[R_IDX], fracA_r[S_IDX])};
        expRnd_s  = exp_r + $signed({9'd0, mantRnd_s[24]});
        if (mantRnd_s[24]) begin
            mantOut_s = mantRnd_s[23:1];
        end else begin
            mantOut_s = mantRnd_s[22:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (in_valid) begin
                    if (special_s) begin
                        next_s = S_ROUND;
                    end else begin
`ifdef ALIGN_FAST_EN
                        next_s = S_ALIGN;
`else
                        next_s = (k_s == 5'd0) ? S_ADD : S_ALIGN;
`endif
                    end
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_ALIGN: begin
`ifdef ALIGN_FAST_EN
                next_s = S_ADD;
`else
                next_s = (alignCnt_r == 5'd1) ? S_ADD : S_ALIGN;
`endif
            end
            S_ADD:   next_s = S_NORM;
            S_NORM:  next_s = S_ROUND;
            S_ROUND: next_s = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    next_s = S_IDLE;
                end else begin
                    next_s = S_DONE;
                end
            end
            default: next_s = S_IDLE;
        endcase
    end

    // Handshake and status outputs, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inReady_r  <= 1'b1;
            outValid_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            inReady_r  <= (next_s == S_IDLE);
            outValid_r <= (next_s == S_DONE);
            busy_r     <= (next_s != S_IDLE);
        end
    end

    // Datapath: capture, align, add, normalise, round/pack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signRes_r    <= 1'b0;
            effSub_r     <= 1'b0;
            special_r    <= 1'b0;
            sumZero_r    <= 1'b0;
            specialRes_r <= 32'd0;
            exp_r        <= 10'sd0;
            fracA_r      <= 27'd0;
            fracB_r      <= 27'd0;
            sum_r        <= 28'd0;
            alignCnt_r   <= 5'd0;
            result_r     <= 32'd0;
            overflow_r   <= 1'b0;
            zero_r       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        signRes_r    <= bigSign_s;
                        effSub_r     <= in_a[31] ^ signB_s;
                        special_r    <= special_s;
                        sumZero_r    <= 1'b0;
                        specialRes_r <= specialCalc_s;
                        exp_r        <= $signed({2'b00, bigMag_s[30:23]});
                        fracA_r      <= unpackFrac(bigMag_s);
                        fracB_r      <= fracSmall_s;
                        alignCnt_r   <= k_s;
                        overflow_r   <= 1'b0;
                        zero_r       <= 1'b0;
                    end
                end
                S_ALIGN: begin
`ifdef ALIGN_FAST_EN
                    fracB_r <= (fracB_r >> alignCnt_r) |
                               {26'd0, |(fracB_r & ~({FRAC_W{1'b1}} << alignCnt_r))};
`else
                    fracB_r    <= {1'b0, fracB_r[FRAC_W-1:2], fracB_r[1] | fracB_r[0]};
                    alignCnt_r <= alignCnt_r - 5'd1;
`endif
                end
                S_ADD: begin
                    if (effSub_r) begin
                        sum_r <= {1'b0, fracA_r} - {1'b0, fracB_r};
                    end else begin
                        sum_r <= {1'b0, fracA_r} + {1'b0, fracB_r};
                    end
                end
                S_NORM: begin
                    if (sum_r == 28'd0) begin
                        sumZero_r <= 1'b1;
                        fracA_r   <= 27'd0;
                    end else if (sum_r[FRAC_W] && !effSub_r) begin
                        fracA_r <= {sum_r[FRAC_W:2], sum_r[1] | sum_r[0]};
                        exp_r   <= exp_r + 10'sd1;
                    end else begin
                        fracA_r <= sum_r[FRAC_W-1:0] << lzc_s;
                        exp_r   <= exp_r - $signed({5'd0, lzc_s});
                    end
                end
                S_ROUND: begin
                    if (special_r) begin
                        result_r <= specialRes_r;
                    end else if (sumZero_r) begin
                        result_r <= 32'd0;
                        zero_r   <= 1'b1;
                    end else if (expRnd_s >= 10'sd255) begin
                        result_r   <= {signRes_r, EXP_MAX, 23'd0};
                        overflow_r <= 1'b1;
                    end else if (expRnd_s <= 10'sd0) begin
                        result_r <= {signRes_r, 31'd0};
                        zero_r   <= 1'b1;
                    end else begin
                        result_r <= {signRes_r, expRnd_s[EXP_W-1:0], mantOut_s};
                    end
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign in_ready     = inReady_r;
    assign out_valid    = outValid_r;
    assign busy         = busy_r;
    assign out_result   = result_r;
    assign out_overflow = overflow_r;
    assign out_zero     = zero_r;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed self-checking bench for fp_add_sequencer (honours ALIGN_FAST_EN for latency).
module tb_fp_add_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_sub, out_valid, out_ready;
    logic        out_overflow, out_zero, busy;
    logic [31:0] in_a, in_b, out_result;

    int nCmp = 0;
    int nErr = 0;

    fp_add_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_sub       (in_sub),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_zero     (out_zero),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int expLat(input int k);
`ifdef ALIGN_FAST_EN
        return 4;
`else
        return k + 3;
`endif
    endfunction

    // Issue one operation, measure latency, check result, hold in DONE, then release.
    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] expRes, input logic expOvf,
                         input logic expZero, input int lat, input int hold);
        int   cyc;
        logic rdyLow;
        @(negedge clk);
        check({tag, ".ready_idle"}, in_ready, 1'b1);
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc    = 0;
        rdyLow = 1'b1;
        while (out_valid !== 1'b1 && cyc < 100) begin
            if (in_ready !== 1'b0) rdyLow = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, ".latency"}, cyc, lat);
        check({tag, ".ready_low"}, rdyLow & ~in_ready, 1'b1);
        check({tag, ".busy"}, busy, 1'b1);
        check({tag, ".result"}, out_result, expRes);
        check({tag, ".overflow"}, out_overflow, expOvf);
        check({tag, ".zero"}, out_zero, expZero);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold_result"}, out_result, expRes);
            check({tag, ".hold_valid_ready"}, {out_valid, in_ready}, 2'b10);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".release"}, {out_valid, in_ready, busy}, 3'b010);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
        in_a = 32'd0; in_b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.outputs", {out_valid, in_ready, busy, out_overflow, out_zero}, 5'b01000);
        check("rst.result", out_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        runOp("one_plus_one",  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, expLat(0), 0);
        runOp("clamp_d30",     32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, expLat(27), 0);
        runOp("cancel",        32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 1'b0, 1'b1, expLat(0), 0);
        runOp("lshift2",       32'h3F800000, 32'hBF400000, 1'b0, 32'h3E800000, 1'b0, 1'b0, expLat(1), 0);
        runOp("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, expLat(0), 0);
        runOp("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1, 0);
        runOp("inf_plus_one",  32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 1'b0, 1'b0, 1, 0);
        runOp("rne_up",        32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0, expLat(24), 0);
        runOp("rne_tie_even",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, expLat(24), 0);
        runOp("swap_sub",      32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0, expLat(1), 0);
        runOp("hold5",         32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 1'b0, 1'b0, expLat(1), 5);

        // Reset in the middle of an operation drops it.
        @(negedge clk);
        in_a = 32'h3F800000; in_b = 32'h30800000; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("mid.busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid.rst_outputs", {out_valid, in_ready, busy, out_overflow, out_zero}, 5'b01000);
        check("mid.rst_result", out_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid.idle_after", {out_valid, in_ready, busy}, 3'b010);

        runOp("after_reset",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, expLat(0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
